// File: rtl/mc14500b_sequencer_pkg.sv
// Purpose: shared opcode/state types and helpers for the MC14500B program sequencer.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
//
// Contents: opcode_t covers all 16 MC14500B codes; seq_state_t is the
// sequencer FSM; is_ctrl_op() flags opcodes that change control flow.
package mc14500b_sequencer_pkg;

  localparam int OPC_W = 4;

  typedef enum logic [OPC_W-1:0] {
    OP_NOPO = 4'h0,
    OP_LD   = 4'h1,
    OP_LDC  = 4'h2,
    OP_AND  = 4'h3,
    OP_ANDC = 4'h4,
    OP_OR   = 4'h5,
    OP_ORC  = 4'h6,
    OP_XNOR = 4'h7,
    OP_STO  = 4'h8,
    OP_STOC = 4'h9,
    OP_IEN  = 4'hA,
    OP_OEN  = 4'hB,
    OP_JMP  = 4'hC,
    OP_RTN  = 4'hD,
    OP_SKZ  = 4'hE,
    OP_NOPF = 4'hF
  } opcode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } seq_state_t;

  // SKZ is deliberately absent: the core handles it by raising proc_skip on
  // the following instruction, so the sequencer treats it as a plain opcode.
  function automatic logic is_ctrl_op(input opcode_t op);
    return (op == OP_JMP) || (op == OP_RTN) || (op == OP_NOPF);
  endfunction

endpackage

// File: rtl/mc14500b_sequencer_if.sv
// Purpose: ROM fetch bus plus core instruction bus of the MC14500B sequencer.
// Latency: prog_data is expected one cycle after prog_addr (synchronous ROM).
// Backpressure: none; the core can only suppress via proc_skip.
//
// master (sequencer): drives prog_addr, instr, instr_addr, instr_valid;
//                     receives prog_data (ROM) and proc_skip (core).
// slave  (ROM/core) : the mirror image.
interface mc14500b_sequencer_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] prog_addr;
  logic [ADDR_W+3:0] prog_data;
  logic [3:0]        instr;
  logic [ADDR_W-1:0] instr_addr;
  logic              instr_valid;
  logic              proc_skip;

  modport master (
    output prog_addr, instr, instr_addr, instr_valid,
    input  prog_data, proc_skip
  );

  modport slave (
    input  prog_addr, instr, instr_addr, instr_valid,
    output prog_data, proc_skip
  );
endinterface

// File: rtl/mc14500b_sequencer_seq_return_stack.sv
// Purpose: return-address LIFO for JMP (call) / RTN (return).
// Latency: push/pop take effect at the next clock; top_data is combinational.
// Backpressure: push when full and pop when empty are silently ignored.
//
// Ports: clk, rst (async active-low, clears sp only), push/push_data,
//        pop, top_data (entry at sp-1), full (sp==DEPTH), empty (sp==0).
module seq_return_stack #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] top_data,
  output logic              full,
  output logic              empty
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int SP_W  = IDX_W + 1;

  logic [SP_W-1:0]   sp_q, sp_d, sp_m1;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  assign full     = (sp_q == SP_W'(DEPTH));
  assign empty    = (sp_q == '0);
  assign sp_m1    = sp_q - SP_W'(1);
  assign top_data = mem_q[sp_m1[IDX_W-1:0]];

  always_comb begin
    sp_d  = sp_q;
    mem_d = mem_q;
    if (push && !full) begin
      mem_d[sp_q[IDX_W-1:0]] = push_data;
      sp_d                   = sp_q + SP_W'(1);
    end else if (pop && !empty) begin
      sp_d = sp_m1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sp_q <= '0;
    end else begin
      sp_q <= sp_d;
    end
  end

  // Contents are not reset: with sp back at 0 stale entries are unreachable.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/mc14500b_sequencer.sv
// Purpose: program sequencer (PC, call/return stack, halt) for the MC14500B core.
// Latency: 2 cycles per instruction (FETCH drives prog_addr, EXEC presents instr).
// Backpressure: none; proc_skip only turns the current instruction into pc+1.
//
// Ports: clk, rst (async active-low), start (pulse: IDLE->run, HALT->resume),
//        bus (master side of mc14500b_sequencer_if: ROM + core buses),
//        pc, halted, busy, stack_ovf / stack_unf (sticky, cleared on IDLE start).
module mc14500b_sequencer
  import mc14500b_sequencer_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  mc14500b_sequencer_if.master bus,
  output logic [ADDR_W-1:0]    pc,
  output logic                 halted,
  output logic                 busy,
  output logic                 stack_ovf,
  output logic                 stack_unf
);

  seq_state_t        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] instr_addr_q, instr_addr_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;

  opcode_t           op;
  logic [ADDR_W-1:0] field;
  logic [ADDR_W-1:0] pc_inc;
  logic              in_exec;

  logic              stk_push, stk_pop;
  logic              stk_full, stk_empty;
  logic [ADDR_W-1:0] stk_top;

  assign op      = opcode_t'(bus.prog_data[ADDR_W +: OPC_W]);
  assign field   = bus.prog_data[ADDR_W-1:0];
  assign pc_inc  = pc_q + ADDR_W'(1);  // wraps modulo 2^ADDR_W
  assign in_exec = (state_q == EXEC);

  seq_return_stack #(
    .DEPTH  (STACK_DEPTH),
    .DATA_W (ADDR_W)
  ) u_stack (
    .clk       (clk),
    .rst       (rst),
    .push      (stk_push),
    .push_data (pc_inc),
    .pop       (stk_pop),
    .top_data  (stk_top),
    .full      (stk_full),
    .empty     (stk_empty)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_addr_d = instr_addr_q;
    ovf_d        = ovf_q;
    unf_d        = unf_q;
    stk_push     = 1'b0;
    stk_pop      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
        end
      end

      FETCH: state_d = EXEC;

      EXEC: begin
        instr_addr_d = field;
        state_d      = FETCH;
        pc_d         = pc_inc;
        // A skipped instruction is a pure pc+1, whatever its opcode.
        if (!bus.proc_skip && is_ctrl_op(op)) begin
          case (op)
            OP_JMP: begin
              // The jump always happens; only the push is dropped when full.
              pc_d = field;
              if (stk_full) begin
                ovf_d = 1'b1;
              end else begin
                stk_push = 1'b1;
              end
            end
            OP_RTN: begin
              if (stk_empty) begin
                unf_d = 1'b1;
              end else begin
                stk_pop = 1'b1;
                pc_d    = stk_top;
              end
            end
            OP_NOPF: state_d = HALT;
            default: ;
          endcase
        end
      end

      HALT: begin
        // Resume keeps the sticky flags; only a fresh start from IDLE clears them.
        if (start) begin
          state_d = FETCH;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      pc_q         <= '0;
      instr_addr_q <= '0;
      ovf_q        <= 1'b0;
      unf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_addr_q <= instr_addr_d;
      ovf_q        <= ovf_d;
      unf_q        <= unf_d;
    end
  end

  // prog_addr follows pc; the ROM is only consumed on the EXEC after FETCH.
  assign bus.prog_addr   = pc_q;
  assign bus.instr       = in_exec ? op : OP_NOPO;
  assign bus.instr_addr  = in_exec ? field : instr_addr_q;
  assign bus.instr_valid = in_exec;

  assign pc        = pc_q;
  assign halted    = (state_q == HALT);
  assign busy      = (state_q == FETCH) || in_exec;
  assign stack_ovf = ovf_q;
  assign stack_unf = unf_q;

endmodule

// File: doc/mc14500b_sequencer.md
Name: mc14500b_sequencer

Overview:
- Program sequencer for the MC14500B 1-bit processor core. The core has no program counter of its own.
- Fetches program words from a synchronous program ROM and presents opcode plus I/O address to the core, one instruction at a time.
- Resolves control flow from the fetched opcode: JMP as call with push, RTN as return with pop, NOPF as halt.
- Sits between the program ROM and the core; the only external control is a start pulse.

Parameters:
- ADDR_W, 8, width of PC, jump target and I/O select field.
- STACK_DEPTH, 4, number of return-address entries (power of 2, ≥2).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; starts from IDLE or resumes from HALT.
- prog_addr  out  ADDR_W  ROM read address.
- prog_data  in  4+ADDR_W  ROM word {opcode[3:0], field[ADDR_W-1:0]}; valid 1 cycle after prog_addr.
- instr  out  4  opcode to core.
- instr_addr  out  ADDR_W  I/O select field to core.
- instr_valid  out  1  core executes instr this cycle.
- proc_skip  in  1  core is suppressing the current instruction (prior SKZ/RTN).
- pc  out  ADDR_W  current program counter.
- halted  out  1  high in HALT.
- busy  out  1  high in FETCH/EXEC.
- stack_ovf  out  1  sticky: push attempted with stack full.
- stack_unf  out  1  sticky: pop attempted with stack empty.

Behaviour:
- Reset (asynchronous assert, rst=0):
  - state=IDLE; pc=0; sp=0; prog_addr=0.
  - instr=NOPO (4'h0); instr_addr=0.
  - instr_valid, halted, busy, stack_ovf, stack_unf all 0.
- Opcode encodings come from the instructions package: NOPO=0 … JMP=C, RTN=D, SKZ=E, NOPF=F.
- FSM states: IDLE, FETCH, EXEC, HALT.
- IDLE:
  - start → FETCH, clearing stack_ovf and stack_unf.
  - Otherwise hold.
- FETCH:
  - prog_addr=pc; busy=1.
  - Next cycle → EXEC unconditionally.
- EXEC:
  - Register prog_data into instr/instr_addr; instr_valid=1 for exactly this cycle.
  - Each instruction takes 2 cycles (FETCH+EXEC).
  - Next-PC rules, evaluated in EXEC:
    - proc_skip=1: pc←pc+1, no stack action, no halt, regardless of opcode.
    - JMP: pc←field. If sp<STACK_DEPTH, push pc+1 and sp++. Else set stack_ovf, drop the push, and still jump.
    - RTN: if sp>0, pc←stack[sp-1] and sp--. Else set stack_unf and pc←pc+1. The core itself skips the instruction following RTN; the sequencer does not add extra skipping.
    - NOPF: pc←pc+1, go to HALT. Core still sees NOPF with instr_valid=1 so it can raise FLAGF.
    - All other opcodes: pc←pc+1, go to FETCH.
- HALT:
  - halted=1; instr=NOPO; instr_valid=0.
  - start → FETCH at the held pc. Sticky flags are not cleared on resume.
- Arithmetic:
  - pc+1 is modulo 2^ADDR_W: 0xFF→0x00 for ADDR_W=8.
  - The pushed return address wraps the same way.
- start while busy is ignored.
- Outside EXEC: instr=NOPO, instr_valid=0, instr_addr holds its last value.
- Reset mid-instruction aborts immediately:
  - The stack contents are not cleared; sp=0 makes them unreachable.
  - No partial push or pop is visible after reset.
- Simultaneous JMP with full stack: the jump wins and the overflow flag is set in the same cycle. stack_ovf is visible the cycle after EXEC.

Decomposition:
- instructions package gets:
  - opcode enum (or verify the existing one covers all 16 codes);
  - typedef seq_state_t {IDLE, FETCH, EXEC, HALT};
  - function is_ctrl_op(opcode).
- Natural sub-module: seq_return_stack. A LIFO with push/pop/full/empty and STACK_DEPTH parameter, with the same async active-low reset on sp only.
- PC, FSM and flags live in the top module.

Test Plan:
- Reset then start, ROM 0:LD 3, 1:STO 2, 2:NOPF → instr_valid pulses at cycles 2,4,6 with (1,3), (8,2), (F,x). Then halted=1, pc=3.
- ROM 0:JMP 0x10, 0x10:RTN → pc 0→0x10→0x01; sp 0→1→0; no sticky flags.
- Five nested JMPs with STACK_DEPTH=4 → fifth JMP still lands on its target; stack_ovf=1 from the next cycle; sp stays 4.
- RTN with empty stack at pc=5 → pc=6, stack_unf=1; next start from HALT/IDLE clears it only via IDLE.
- JMP at pc=7 with proc_skip=1 → pc=8, sp unchanged; NOPF with proc_skip=1 does not halt. PC wrap: NOPO at 0xFF → next fetch at 0x00.
- rst pulsed low during EXEC of a JMP → all outputs at reset values within the same cycle; sp=0; after start, fetch restarts at 0.
